onehot_dispatch_decoder: RTL
============================

// Module: onehot_dispatch_decoder
// PURPOSE
//  Receiving end of the priority-encoder interface. Accepts encoded request codes
//  {valid, code} over a valid/ready handshake and buffers them in a small FIFO.
//  Drives each code out as a held one-hot strobe until the consumer acknowledges it.
//  Sits between the priority encoder and per-channel service logic, replaying codes in arrival order.
// PARAMETERS
//  CODE_W  2  width of incoming code; N = 1<<CODE_W one-hot outputs (localparam)
//  DEPTH   4  FIFO entries, power of two, >= 2
// PORTS
//  clk         in   1               rising-edge clock
//  rst_n       in   1               synchronous, active-low reset
//  in_valid    in   1               code present on in_code
//  in_code     in   CODE_W          encoded index (priority-encoder y output)
//  in_ready    out  1               FIFO can accept (= !full)
//  out_valid   out  1               out_onehot holds a live request
//  out_onehot  out  N               1 << current code; all zero when !out_valid
//  out_ack     in   1               consumer done with current request
//  fifo_count  out  $clog2(DEPTH)+1 entries currently buffered
//  busy        out  1               out_valid | (fifo_count != 0)
// BEHAVIOUR
//  - Reset (rst_n==0 at a rising edge): FIFO flushed, rd/wr ptrs = 0, fifo_count = 0,
//    state = IDLE, out_valid = 0, out_onehot = 0, busy = 0.
//  - Reset mid-operation: pending and active requests are discarded; no out_ack is required.
//  - Push: in_valid & in_ready at an edge writes in_code. in_ready = (fifo_count != DEPTH).
//    When full, a push is refused even if a pop happens in the same cycle.
//  - Pointers wrap modulo DEPTH. fifo_count uses DEPTH+1 encodings.
//  - Simultaneous push and pop leaves fifo_count unchanged.
//  - FSM, 2 states:
//    IDLE:   FIFO non-empty -> pop head, out_onehot <= 1<<head, out_valid <= 1, go ACTIVE.
//    ACTIVE: hold out_onehot/out_valid stable while !out_ack.
//            out_ack & FIFO non-empty -> pop, load next code in the same edge, stay ACTIVE
//            (back-to-back, no bubble).
//            out_ack & FIFO empty -> out_valid <= 0, out_onehot <= 0, go IDLE.
//  - Latency: a code pushed at edge k into an empty FIFO while IDLE drives out_valid
//    from edge k+1. It is not bypassed combinationally.
//  - out_ack while !out_valid is ignored.
//  - A push into an empty FIFO and an ack in the same cycle: the new code is popped on the following edge.
//  - Exactly one out_onehot bit is set whenever out_valid==1.
//  - in_code is always in range (full 2^CODE_W space). No invalid-code case exists.
// CONFIGURATION
//  COALESCE_EN defined: an accepted push whose in_code equals the most recently written,
//    still-buffered entry (FIFO non-empty) is consumed (handshake completes) but not stored.
//    fifo_count does not change. Codes matching only the active output are still stored.
//  COALESCE_EN undefined: every accepted push is stored. Duplicates are replayed.
// STRUCTURE
//  - Package dispatch_pkg: CODE_W default, state typedef {IDLE, ACTIVE}, onehot(code) function.
//  - Sub-module code_fifo: synchronous FIFO (DEPTH x CODE_W) with push/pop/full/empty/count.
//    The top holds the FSM, the output registers and the coalesce compare.
// TESTING
//  1. Reset held 3 cycles with in_valid=1 -> in_ready=1, out_valid=0, out_onehot=0000,
//     fifo_count=0 throughout.
//  2. Push code 2 into idle block -> edge after accept: out_onehot=0100, out_valid=1.
//     Hold 5 cycles without ack: stable. Pulse ack: out_valid=0 next edge.
//  3. Push 0,1,3,2 with out_ack held low -> fifo_count reaches 3 (first popped), in_ready stays 1.
//     Push 1,1 (5th/6th codes): count 4, then in_ready=0.
//     Ack every cycle -> outputs 0001,0010,1000,0100,0010,0010 back-to-back, no gap.
//  4. Full FIFO, push attempt with same-cycle ack -> push refused (in_ready=0),
//     count drops by 1, code not stored.
//  5. Two codes pending, rst_n low mid-ACTIVE -> next edge out_valid=0, fifo_count=0.
//     After release, no stale codes appear.
//  6. COALESCE_EN: push 3,3,3,1 while ACTIVE and unacked -> fifo_count=2, outputs 1000 then 0010.
//     Without COALESCE_EN: fifo_count=4, four outputs.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types and helpers for the one-hot dispatch decoder.
package dispatch_pkg;

    localparam int DEF_CODE_W = 2;
    // Widest one-hot the helper can produce; limits CODE_W to 8.
    localparam int MAX_N      = 256;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [7:0] code);
        onehot = {{(MAX_N-1){1'b0}}, 1'b1} << code;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous DEPTH x W FIFO with first-word-fall-through read; pushes while
// full and pops while empty are dropped internally.
module code_fifo
    import dispatch_pkg::*;
#(
    parameter  int W     = DEF_CODE_W,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage is not reset; the pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/onehot_dispatch_decoder.sv
// Buffers encoded request codes and replays each as a held one-hot strobe until acked.
// Optional COALESCE_EN drops a push that repeats the newest still-buffered code.
module onehot_dispatch_decoder
    import dispatch_pkg::*;
#(
    parameter  int CODE_W = DEF_CODE_W,
    parameter  int DEPTH  = 4,
    localparam int N      = 1 << CODE_W,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_onehot,
    input  logic              out_ack,
    output logic [CW-1:0]     fifo_count,
    output logic              busy
);

    state_t            r_state, w_state_nxt;
    logic              r_valid, w_valid_nxt;
    logic [N-1:0]      r_onehot, w_onehot_nxt;
    logic              w_full, w_empty;
    logic              w_accept, w_push, w_pop;
    logic [CODE_W-1:0] w_head;
    logic [CW-1:0]     w_count;

    assign w_accept = in_valid & ~w_full;

`ifdef COALESCE_EN
    logic [CODE_W-1:0] r_last_code;
    logic              w_tail_live;
    logic              w_dup;

    // The newest entry is only a coalesce target if it stays buffered past this
    // edge; once it is being popped into the output it no longer counts.
    assign w_tail_live = ~w_empty & ~(w_pop & (w_count == CW'(1)));
    assign w_dup       = w_tail_live & (in_code == r_last_code);
    assign w_push      = w_accept & ~w_dup;

    always_ff @(posedge clk) begin
        if (!rst_n)      r_last_code <= '0;
        else if (w_push) r_last_code <= in_code;
    end
`else
    assign w_push = w_accept;
`endif

    code_fifo #(
        .W     (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (in_code),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_valid_nxt  = r_valid;
        w_onehot_nxt = r_onehot;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_nxt  = ACTIVE;
                    w_valid_nxt  = 1'b1;
                    w_onehot_nxt = N'(onehot(8'(w_head)));
                end
            end
            ACTIVE: begin
                if (out_ack) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_onehot_nxt = N'(onehot(8'(w_head)));
                    end else begin
                        w_state_nxt  = IDLE;
                        w_valid_nxt  = 1'b0;
                        w_onehot_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_valid_nxt  = 1'b0;
                w_onehot_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_onehot <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_valid  <= w_valid_nxt;
            r_onehot <= w_onehot_nxt;
        end
    end

    assign in_ready   = ~w_full;
    assign out_valid  = r_valid;
    assign out_onehot = r_onehot;
    assign fifo_count = w_count;
    assign busy       = r_valid | ~w_empty;

    a_onehot:    assert property (@(posedge clk) disable iff (!rst_n) r_valid |-> $onehot(r_onehot));
    a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n) !r_valid |-> (r_onehot == '0));
    a_hold:      assert property (@(posedge clk) disable iff (!rst_n)
                                  (r_valid && !out_ack) |=> (r_valid && $stable(r_onehot)));

endmodule
